// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC generator: kind encoding, BTB entry and sequential target.
package npc_pkg;

    localparam logic [2:0] NOT_JUMP = 3'd0;
    localparam logic [2:0] DIRECT   = 3'd1;
    localparam logic [2:0] JUMP     = 3'd2;
    localparam logic [2:0] CALL     = 3'd3;
    localparam logic [2:0] RET      = 3'd4;
    localparam logic [2:0] INDIRECT = 3'd5;
    localparam logic [2:0] OTHER    = 3'd6;

    localparam int unsigned NPC_ADDR_W = 30;
    localparam int unsigned NPC_TAG_W  = 10;

    typedef struct packed {
        logic                  valid;
        logic [NPC_TAG_W-1:0]  tag;
        logic [NPC_ADDR_W-1:0] target;
    } btb_entry_t;

    // Start of the next aligned fetch block; wraps naturally at the address width.
    function automatic logic [NPC_ADDR_W-1:0] seq_target(input logic [NPC_ADDR_W-1:0] pc,
                                                         input int unsigned fetch_w);
        logic [NPC_ADDR_W-1:0] mask;
        mask = ~(NPC_ADDR_W'(fetch_w - 1));
        return (pc & mask) + NPC_ADDR_W'(fetch_w);
    endfunction

endpackage

// File: rtl/npc_ras_spec.sv
// Speculative return-address stack with checkpoint restore.
// Optional recursion counters per entry under NPC_RAS_RECUR_CNT_EN.
module npc_ras_spec
    import npc_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned PtrW  = 4,
    parameter int unsigned AddrW = NPC_ADDR_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             spec_push_i,
    input  logic             spec_pop_i,
    input  logic [AddrW-1:0] spec_addr_i,
    input  logic             rec_en_i,
    input  logic [PtrW-1:0]  rec_ptr_i,
    input  logic [PtrW:0]    rec_cnt_i,
    input  logic             rec_push_i,
    input  logic             rec_pop_i,
    input  logic [AddrW-1:0] rec_addr_i,
`ifdef NPC_RAS_RECUR_CNT_EN
    input  logic [1:0]       rec_rc_i,
    output logic [1:0]       top_rc_o,
`endif
    output logic [AddrW-1:0] top_o,
    output logic [PtrW-1:0]  ptr_o,
    output logic [PtrW:0]    cnt_o
);

    logic [AddrW-1:0] mem_q [Depth];
    logic [PtrW-1:0]  ptr_q, ptr_d, base_ptr, wr_ptr;
    logic [PtrW:0]    cnt_q, cnt_d, base_cnt;
    logic             push, pop, wr_en;
    logic [AddrW-1:0] addr;

`ifdef NPC_RAS_RECUR_CNT_EN
    logic [1:0] rc_q [Depth];
    logic [1:0] base_rc, rc_new;
    logic       rc_upd;
`endif

    // A mispredict recovery replaces the speculative op of the same cycle.
    always_comb begin
        base_ptr = rec_en_i ? rec_ptr_i  : ptr_q;
        base_cnt = rec_en_i ? rec_cnt_i  : cnt_q;
        push     = rec_en_i ? rec_push_i : spec_push_i;
        pop      = rec_en_i ? rec_pop_i  : spec_pop_i;
        addr     = rec_en_i ? rec_addr_i : spec_addr_i;
        ptr_d    = base_ptr;
        cnt_d    = base_cnt;
        wr_ptr   = base_ptr + PtrW'(1);
        wr_en    = 1'b0;
`ifdef NPC_RAS_RECUR_CNT_EN
        base_rc  = rec_en_i ? rec_rc_i : rc_q[ptr_q];
        rc_new   = base_rc;
        rc_upd   = 1'b0;
        if (push && base_cnt != '0 && mem_q[base_ptr] == addr) begin
            rc_upd = 1'b1;
            rc_new = (base_rc == 2'd3) ? 2'd3 : base_rc + 2'd1;
        end else if (pop && base_cnt != '0 && base_rc != 2'd0) begin
            rc_upd = 1'b1;
            rc_new = base_rc - 2'd1;
        end else
`endif
        if (push) begin
            wr_en = 1'b1;
            ptr_d = wr_ptr;
            cnt_d = (base_cnt == (PtrW+1)'(Depth)) ? base_cnt : base_cnt + (PtrW+1)'(1);
        end else if (pop && base_cnt != '0) begin
            ptr_d = base_ptr - PtrW'(1);
            cnt_d = base_cnt - (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= addr;
    end

`ifdef NPC_RAS_RECUR_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(Depth); i++) rc_q[i] <= 2'd0;
        end else begin
            if (rec_en_i) rc_q[rec_ptr_i] <= rec_rc_i;
            if (wr_en) rc_q[wr_ptr] <= 2'd0;
            else if (rc_upd) rc_q[base_ptr] <= rc_new;
        end
    end

    assign top_rc_o = rc_q[ptr_q];
`endif

    assign top_o = mem_q[ptr_q];
    assign ptr_o = ptr_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/npc_gen_ras_ckpt.sv
// Fetch-stage next-PC generator: direct-mapped BTB, speculative RAS, sequential incrementer.
// Define NPC_RAS_RECUR_CNT_EN to add RAS recursion counters and the ras_top_rc checkpoint.
module npc_gen_ras_ckpt
    import npc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = NPC_ADDR_W,
    parameter int unsigned BTB_IDX_W  = 8,
    parameter int unsigned BTB_TAG_W  = NPC_TAG_W,
    parameter int unsigned RAS_DEPTH  = 16,
    parameter int unsigned RAS_PTR_W  = $clog2(RAS_DEPTH),
    parameter int unsigned FETCH_W    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  pc_valid_i,
    input  logic [2:0]            kind_pdc_i,
    input  logic                  taken_pdc_i,
    output logic [ADDR_WIDTH-1:0] npc_pdc_o,
    output logic                  btb_hit_o,
    output logic [RAS_PTR_W-1:0]  ras_ptr_ckpt_o,
    output logic [RAS_PTR_W:0]    ras_cnt_ckpt_o,
    input  logic                  upd_en_i,
    input  logic [ADDR_WIDTH-1:0] upd_pc_i,
    input  logic [ADDR_WIDTH-1:0] upd_target_i,
    input  logic [2:0]            upd_kind_i,
    input  logic                  upd_taken_i,
    input  logic                  upd_mis_i,
    input  logic [RAS_PTR_W-1:0]  upd_ras_ptr_i,
    input  logic [RAS_PTR_W:0]    upd_ras_cnt_i
`ifdef NPC_RAS_RECUR_CNT_EN
    ,
    input  logic [1:0]            upd_ras_top_rc_i,
    output logic [1:0]            ras_top_rc_o
`endif
);

    localparam int unsigned BtbEntries = 2 ** BTB_IDX_W;

    btb_entry_t            btb_q [BtbEntries];
    btb_entry_t            rd_entry;
    logic                  btb_we, rec_en, kind_ok;
    logic [ADDR_WIDTH-1:0] ras_top;

    assign rd_entry  = btb_q[pc_i[BTB_IDX_W-1:0]];
    assign btb_hit_o = rd_entry.valid && (rd_entry.tag == pc_i[BTB_IDX_W +: BTB_TAG_W]);
    assign btb_we    = upd_en_i && upd_taken_i && (upd_kind_i != NOT_JUMP);
    assign rec_en    = upd_en_i && upd_mis_i;
    assign kind_ok   = (kind_pdc_i <= OTHER);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(BtbEntries); i++) btb_q[i].valid <= 1'b0;
        end else if (btb_we) begin
            btb_q[upd_pc_i[BTB_IDX_W-1:0]] <= '{valid:  1'b1,
                                                tag:    upd_pc_i[BTB_IDX_W +: BTB_TAG_W],
                                                target: upd_target_i};
        end
    end

    always_comb begin
        npc_pdc_o = seq_target(pc_i, FETCH_W);
        if (taken_pdc_i && kind_ok && kind_pdc_i != NOT_JUMP) begin
            if (kind_pdc_i == RET && ras_cnt_ckpt_o != '0) npc_pdc_o = ras_top;
            else if (btb_hit_o) npc_pdc_o = rd_entry.target;
        end
    end

    npc_ras_spec #(
        .Depth (RAS_DEPTH),
        .PtrW  (RAS_PTR_W),
        .AddrW (ADDR_WIDTH)
    ) u_ras (
        .clk         (clk),
        .rstn        (rstn),
        .spec_push_i (pc_valid_i && taken_pdc_i && kind_pdc_i == CALL),
        .spec_pop_i  (pc_valid_i && taken_pdc_i && kind_pdc_i == RET),
        .spec_addr_i (pc_i + ADDR_WIDTH'(1)),
        .rec_en_i    (rec_en),
        .rec_ptr_i   (upd_ras_ptr_i),
        .rec_cnt_i   (upd_ras_cnt_i),
        .rec_push_i  (upd_kind_i == CALL),
        .rec_pop_i   (upd_kind_i == RET),
        .rec_addr_i  (upd_pc_i + ADDR_WIDTH'(1)),
`ifdef NPC_RAS_RECUR_CNT_EN
        .rec_rc_i    (upd_ras_top_rc_i),
        .top_rc_o    (ras_top_rc_o),
`endif
        .top_o       (ras_top),
        .ptr_o       (ras_ptr_ckpt_o),
        .cnt_o       (ras_cnt_ckpt_o)
    );

endmodule

// File: tb/tb_npc_gen_ras_ckpt.sv
// Scoreboard bench for npc_gen_ras_ckpt: driver queues expectations, negedge monitor checks them.
module tb_npc_gen_ras_ckpt;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [29:0] pc_i = '0;
    logic        pc_valid_i = 1'b0;
    logic [2:0]  kind_pdc_i = 3'd0;
    logic        taken_pdc_i = 1'b0;
    logic [29:0] npc_pdc_o;
    logic        btb_hit_o;
    logic [3:0]  ras_ptr_ckpt_o;
    logic [4:0]  ras_cnt_ckpt_o;
    logic        upd_en_i = 1'b0;
    logic [29:0] upd_pc_i = '0;
    logic [29:0] upd_target_i = '0;
    logic [2:0]  upd_kind_i = 3'd0;
    logic        upd_taken_i = 1'b0;
    logic        upd_mis_i = 1'b0;
    logic [3:0]  upd_ras_ptr_i = '0;
    logic [4:0]  upd_ras_cnt_i = '0;
`ifdef NPC_RAS_RECUR_CNT_EN
    logic [1:0]  upd_ras_top_rc_i = '0;
    logic [1:0]  ras_top_rc_o;
`endif

    localparam logic [2:0] KDIR = 3'd1, KCALL = 3'd3, KRET = 3'd4;

    typedef struct {
        string       nm;
        logic [29:0] npc;
        logic        hit;
        logic [3:0]  ptr;
        logic [4:0]  cnt;
        logic [1:0]  rc;
        bit          chk_rc;
    } exp_t;

    exp_t exp_q[$];
    logic obs = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    npc_gen_ras_ckpt u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .pc_i           (pc_i),
        .pc_valid_i     (pc_valid_i),
        .kind_pdc_i     (kind_pdc_i),
        .taken_pdc_i    (taken_pdc_i),
        .npc_pdc_o      (npc_pdc_o),
        .btb_hit_o      (btb_hit_o),
        .ras_ptr_ckpt_o (ras_ptr_ckpt_o),
        .ras_cnt_ckpt_o (ras_cnt_ckpt_o),
        .upd_en_i       (upd_en_i),
        .upd_pc_i       (upd_pc_i),
        .upd_target_i   (upd_target_i),
        .upd_kind_i     (upd_kind_i),
        .upd_taken_i    (upd_taken_i),
        .upd_mis_i      (upd_mis_i),
        .upd_ras_ptr_i  (upd_ras_ptr_i),
`ifdef NPC_RAS_RECUR_CNT_EN
        .upd_ras_top_rc_i (upd_ras_top_rc_i),
        .ras_top_rc_o     (ras_top_rc_o),
`endif
        .upd_ras_cnt_i  (upd_ras_cnt_i)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every observed cycle consumes one expectation.
    always @(negedge clk) begin
        if (obs) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: observed cycle got no entry expected one");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                cmp(e.nm, "npc", 32'(npc_pdc_o), 32'(e.npc));
                cmp(e.nm, "hit", 32'(btb_hit_o), 32'(e.hit));
                cmp(e.nm, "ptr", 32'(ras_ptr_ckpt_o), 32'(e.ptr));
                cmp(e.nm, "cnt", 32'(ras_cnt_ckpt_o), 32'(e.cnt));
`ifdef NPC_RAS_RECUR_CNT_EN
                if (e.chk_rc) cmp(e.nm, "rc", 32'(ras_top_rc_o), 32'(e.rc));
`endif
            end
        end
    end

    task automatic fetch(input string nm, input logic [29:0] pc, input logic [2:0] kind,
                         input logic tk, input logic [29:0] npc, input logic hit,
                         input int ptr, input int cnt, input int rc, input bit chk_rc);
        exp_t e;
        @(posedge clk);
        #1;
        upd_en_i    = 1'b0;
        upd_mis_i   = 1'b0;
        pc_i        = pc;
        pc_valid_i  = 1'b1;
        kind_pdc_i  = kind;
        taken_pdc_i = tk;
        e.nm = nm; e.npc = npc; e.hit = hit; e.ptr = 4'(ptr); e.cnt = 5'(cnt);
        e.rc = 2'(rc); e.chk_rc = chk_rc;
        exp_q.push_back(e);
        obs = 1'b1;
    endtask

    initial begin
        #12;
        rstn = 1'b1;
        fetch("reset", 30'h10, 3'd0, 1'b0, 30'h12, 1'b0, 0, 0, 0, 1'b1);

        @(posedge clk);
        #1;
        obs = 1'b0;
        pc_valid_i = 1'b0;
        upd_en_i = 1'b1; upd_pc_i = 30'h100; upd_target_i = 30'h400;
        upd_kind_i = KDIR; upd_taken_i = 1'b1; upd_mis_i = 1'b0;

        fetch("btb_hit", 30'h100, KDIR, 1'b1, 30'h400, 1'b1, 0, 0, 0, 1'b0);
        fetch("btb_tag_miss", 30'h900, KDIR, 1'b1, 30'h902, 1'b0, 0, 0, 0, 1'b0);
        fetch("call", 30'h200, KCALL, 1'b1, 30'h202, 1'b0, 0, 0, 0, 1'b0);
        fetch("ret", 30'h250, KRET, 1'b1, 30'h201, 1'b0, 1, 1, 0, 1'b1);
        fetch("ret_empty", 30'h250, KRET, 1'b1, 30'h252, 1'b0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 17; i++)
            fetch("call_fill", 30'(i), KCALL, 1'b1, 30'((i & ~1) + 2), 1'b0,
                  i % 16, (i > 16) ? 16 : i, 0, 1'b0);
        for (int j = 0; j < 16; j++)
            fetch("ret_drain", 30'h250, KRET, 1'b1, 30'(17 - j), 1'b0,
                  (17 - j) % 16, 16 - j, 0, 1'b0);
        fetch("ret_fallback", 30'h100, KRET, 1'b1, 30'h400, 1'b1, 1, 0, 0, 1'b0);

        fetch("mis_call_a", 30'h20, KCALL, 1'b1, 30'h22, 1'b0, 1, 0, 0, 1'b0);
        fetch("mis_call_b", 30'h30, KCALL, 1'b1, 30'h32, 1'b0, 2, 1, 0, 1'b0);
        fetch("mis_cycle", 30'h40, KCALL, 1'b1, 30'h42, 1'b0, 3, 2, 0, 1'b0);
        upd_en_i = 1'b1; upd_mis_i = 1'b1; upd_pc_i = 30'h300; upd_target_i = 30'h0;
        upd_kind_i = KCALL; upd_taken_i = 1'b0; upd_ras_ptr_i = 4'd0; upd_ras_cnt_i = 5'd0;
        fetch("mis_repaired", 30'h250, KRET, 1'b1, 30'h301, 1'b0, 1, 1, 0, 1'b1);
        fetch("mis_empty", 30'h250, KRET, 1'b1, 30'h252, 1'b0, 0, 0, 0, 1'b0);

`ifdef NPC_RAS_RECUR_CNT_EN
        fetch("rec_call1", 30'h200, KCALL, 1'b1, 30'h202, 1'b0, 0, 0, 0, 1'b0);
        fetch("rec_call2", 30'h200, KCALL, 1'b1, 30'h202, 1'b0, 1, 1, 0, 1'b1);
        fetch("rec_call3", 30'h200, KCALL, 1'b1, 30'h202, 1'b0, 1, 1, 1, 1'b1);
        fetch("rec_ret1", 30'h250, KRET, 1'b1, 30'h201, 1'b0, 1, 1, 2, 1'b1);
        fetch("rec_ret2", 30'h250, KRET, 1'b1, 30'h201, 1'b0, 1, 1, 1, 1'b1);
        fetch("rec_ret3", 30'h250, KRET, 1'b1, 30'h201, 1'b0, 1, 1, 0, 1'b1);
        fetch("rec_empty", 30'h250, KRET, 1'b1, 30'h252, 1'b0, 0, 0, 0, 1'b0);
`endif

        // Load some state, then reset mid-operation and expect everything cleared.
        fetch("pre_reset", 30'h60, KCALL, 1'b1, 30'h62, 1'b0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        obs = 1'b0;
        rstn = 1'b0;
        pc_i = 30'h100; kind_pdc_i = KDIR; taken_pdc_i = 1'b1; pc_valid_i = 1'b1;
        begin
            exp_t e;
            e.nm = "mid_reset"; e.npc = 30'h102; e.hit = 1'b0; e.ptr = 4'd0; e.cnt = 5'd0;
            e.rc = 2'd0; e.chk_rc = 1'b1;
            exp_q.push_back(e);
        end
        obs = 1'b1;
        @(posedge clk);
        #1;
        obs = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
